// File: rtl/vc_switch_pkg.sv
// Shared definitions for the ExaNet VC switch input scheduler.
// Holds the scheduler state encoding, the VC-to-class mapping and the default VC geometry.
package vc_switch_pkg;

  localparam int VC_NUM   = 3;
  localparam int PRIO_NUM = 2;
  localparam int N        = VC_NUM * PRIO_NUM;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    RECHECK
  } arb_state_t;

  // Priority class of a VC: VCs are grouped in blocks of vcs_per_class, highest block wins.
  function automatic int vc_class(input int vc, input int vcs_per_class);
    return vc / vcs_per_class;
  endfunction

endpackage

// File: rtl/vc_rr_picker.sv
// Round-robin first-set search over one priority class.
// Returns the first requesting VC at or after ptr, wrapping modulo vc_num.
module vc_rr_picker #(
  parameter int vc_num = 3,
  localparam int PW = (vc_num > 1) ? $clog2(vc_num) : 1
) (
  input  logic [vc_num-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic              found,
  output logic [PW-1:0]     idx
);

  // Walk the class starting at the pointer and keep the first hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < vc_num; k++) begin
      if (!found && req[PW'((int'(ptr) + k) % vc_num)]) begin
        found = 1'b1;
        idx   = PW'((int'(ptr) + k) % vc_num);
      end
    end
  end

endmodule

// File: rtl/vc_input_arbiter.sv
// Per-input-port VC scheduler for the ExaNet VC switch.
// Picks a non-empty VC (strict class priority, round robin inside a class), requests its
// output from the switch allocator, and keeps the VC for up to max_pkts_per_grant packets.
// Optional build macro VC_INPUT_ARB_REQ_TIMEOUT_EN: abandons a request that sees no cts for
// req_timeout cycles and pulses o_timeout.
module vc_input_arbiter
  import vc_switch_pkg::*;
#(
  parameter int vc_num             = VC_NUM,
  parameter int prio_num           = PRIO_NUM,
  parameter int output_num         = 8,
  parameter int max_pkts_per_grant = 2,
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
  parameter int req_timeout        = 64,
`endif
  localparam int NV = vc_num * prio_num,
  localparam int SW = (NV > 1) ? $clog2(NV) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NV-1:0]                       has_packet,
  input  logic [NV-1:0][output_num-1:0]       dest_i,
  input  logic [NV-1:0][SW-1:0]               output_vc_i,
  input  logic                                cts,
  input  logic                                last,
  output logic                                o_req,
  output logic [output_num-1:0]               o_dest,
  output logic [SW-1:0]                       o_out_vc,
  output logic [SW-1:0]                       selected_vc,
  output logic                                o_grant,
  output logic                                o_pkt_done
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
  ,
  output logic                                o_timeout
`endif
);

  localparam int PW = (vc_num > 1) ? $clog2(vc_num) : 1;
  localparam int CW = $clog2(max_pkts_per_grant + 1);

  arb_state_t state;

  logic [PW-1:0]       rr_ptr   [prio_num];
  logic [prio_num-1:0] cls_found;
  logic [PW-1:0]       cls_idx  [prio_num];
  logic [SW-1:0]       win_vc;
  logic                any_pkt;
  logic                sel_has;
  logic [CW-1:0]       pkt_cnt;
  logic [CW-1:0]       cnt_inc;
  logic                quota_hit;
  logic                release_vc;
  int                  sel_cls;
  int                  sel_pos;
  logic [PW-1:0]       adv_ptr;

  // One round-robin search per priority class.
  for (genvar c = 0; c < prio_num; c++) begin : g_cls
    vc_rr_picker #(.vc_num(vc_num)) u_pick (
      .req   (has_packet[c*vc_num +: vc_num]),
      .ptr   (rr_ptr[c]),
      .found (cls_found[c]),
      .idx   (cls_idx[c])
    );
  end

  assign any_pkt    = |has_packet;
  assign sel_has    = has_packet[selected_vc];
  assign cnt_inc    = pkt_cnt + CW'(1);
  assign quota_hit  = (cnt_inc == CW'(max_pkts_per_grant));
  assign o_pkt_done = (state == XFER) && last;

  // Strict priority across classes: a higher class found later in the loop overrides.
  always_comb begin
    win_vc = '0;
    for (int c = 0; c < prio_num; c++) begin
      if (cls_found[c]) win_vc = SW'(c * vc_num + int'(cls_idx[c]));
    end
  end

  // Pointer value that moves the owning class past the VC being released.
  always_comb begin
    sel_cls = vc_class(int'(selected_vc), vc_num);
    sel_pos = int'(selected_vc) % vc_num;
    adv_ptr = (sel_pos + 1 == vc_num) ? '0 : PW'(sel_pos + 1);
  end

`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
  localparam int TW = $clog2(req_timeout + 1);
  logic [TW-1:0] req_timer;
  logic          req_expire;

  // A request expires on its last allowed REQ cycle unless cts or a withdraw takes priority.
  assign req_expire = (state == REQ) && sel_has && !cts && (req_timer == TW'(req_timeout - 1));
  assign o_timeout  = req_expire;
`endif

  // The current VC gives up ownership: withdraw, quota reached, queue drained or timeout.
  always_comb begin
    release_vc = ((state == REQ) && !sel_has) ||
                 ((state == XFER) && last && quota_hit) ||
                 ((state == RECHECK) && !sel_has);
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
    if (req_expire) release_vc = 1'b1;
`endif
  end

  // Per-class round-robin pointers advance only for the class of the released VC.
  for (genvar c = 0; c < prio_num; c++) begin : g_ptr
    always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_ptr[c] <= '0;
      else if (release_vc && (sel_cls == c)) rr_ptr[c] <= adv_ptr;
    end
  end

  // Packets served under the current grant; cleared whenever the VC is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pkt_cnt <= '0;
    else if (release_vc) pkt_cnt <= '0;
    else if ((state == XFER) && last) pkt_cnt <= cnt_inc;
  end

  // Scheduler FSM with registered request/grant outputs and request latching.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      o_req       <= 1'b0;
      o_grant     <= 1'b0;
      o_dest      <= '0;
      o_out_vc    <= '0;
      selected_vc <= '0;
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
      req_timer   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_pkt) begin
            selected_vc <= win_vc;
            o_dest      <= dest_i[win_vc];
            o_out_vc    <= output_vc_i[win_vc];
            o_req       <= 1'b1;
            state       <= REQ;
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
            req_timer   <= '0;
`endif
          end
        end
        REQ: begin
          if (!sel_has) begin
            o_req <= 1'b0;
            state <= IDLE;
          end else if (cts) begin
            o_req   <= 1'b0;
            o_grant <= 1'b1;
            state   <= XFER;
          end
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
          else if (req_expire) begin
            o_req <= 1'b0;
            state <= IDLE;
          end else begin
            req_timer <= req_timer + TW'(1);
          end
`endif
        end
        XFER: begin
          if (last) begin
            o_grant <= 1'b0;
            state   <= quota_hit ? IDLE : RECHECK;
          end
        end
        RECHECK: begin
          if (sel_has) begin
            // The next packet of the same VC may head to a different output.
            o_dest    <= dest_i[selected_vc];
            o_out_vc  <= output_vc_i[selected_vc];
            o_req     <= 1'b1;
            state     <= REQ;
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
            req_timer <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_input_arbiter.sv
// Testbench for vc_input_arbiter: table-driven single-VC sequence, hand-written corner
// sequences and randomized traffic compared against a behavioural scheduler model.
// Honours VC_INPUT_ARB_REQ_TIMEOUT_EN when the design is built with it.
module tb_vc_input_arbiter;

  localparam int VCN  = 3;
  localparam int PRN  = 2;
  localparam int NV   = VCN * PRN;
  localparam int OUTN = 8;
  localparam int SW   = 3;
  localparam int MAXP = 2;
  localparam int TMO  = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NV-1:0]             hp;
  logic [NV-1:0][OUTN-1:0]   dest_i;
  logic [NV-1:0][SW-1:0]     ovc_i;
  logic                      cts;
  logic                      last;
  logic                      o_req;
  logic [OUTN-1:0]           o_dest;
  logic [SW-1:0]             o_out_vc;
  logic [SW-1:0]             selected_vc;
  logic                      o_grant;
  logic                      o_pkt_done;
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
  logic                      o_timeout;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vc_input_arbiter #(
    .vc_num             (VCN),
    .prio_num           (PRN),
    .output_num         (OUTN),
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
    .req_timeout        (TMO),
`endif
    .max_pkts_per_grant (MAXP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .has_packet  (hp),
    .dest_i      (dest_i),
    .output_vc_i (ovc_i),
    .cts         (cts),
    .last        (last),
    .o_req       (o_req),
    .o_dest      (o_dest),
    .o_out_vc    (o_out_vc),
    .selected_vc (selected_vc),
    .o_grant     (o_grant),
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
    .o_timeout   (o_timeout),
`endif
    .o_pkt_done  (o_pkt_done)
  );

  // ---------------- behavioural model ----------------
  int            m_ptr [PRN];
  int            m_sel;
  int            m_served;
  int            m_wait;
  int            m_ovc;
  bit            m_req, m_grant, m_pause;
  logic [OUTN-1:0] m_dest;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit has(input int v);
    return ((hp >> v) & 6'd1) != 6'd0;
  endfunction

  // Highest non-empty class, then first set VC at or after that class's pointer.
  function automatic int pick(input logic [NV-1:0] h);
    for (int c = PRN - 1; c >= 0; c--) begin
      for (int k = 0; k < VCN; k++) begin
        int v;
        v = c * VCN + (m_ptr[c] + k) % VCN;
        if (((h >> v) & 6'd1) != 6'd0) return v;
      end
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < PRN; c++) m_ptr[c] = 0;
    m_sel = 0; m_served = 0; m_wait = 0; m_ovc = 0;
    m_req = 0; m_grant = 0; m_pause = 0; m_dest = '0;
  endtask

  task automatic m_release();
    m_ptr[m_sel / VCN] = (m_sel % VCN + 1) % VCN;
    m_served = 0;
  endtask

  task automatic m_latch();
    m_dest = dest_i[m_sel[2:0]];
    m_ovc  = int'(ovc_i[m_sel[2:0]]);
    m_wait = 0;
    m_req  = 1;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic m_step();
    if (m_req) begin
      if (!has(m_sel)) begin
        m_req = 0; m_release();
      end else if (cts) begin
        m_req = 0; m_grant = 1;
      end
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
      else if (m_wait == TMO - 1) begin
        m_req = 0; m_release();
      end else begin
        m_wait++;
      end
`endif
    end else if (m_grant) begin
      if (last) begin
        m_grant = 0;
        m_served++;
        if (m_served == MAXP) m_release();
        else m_pause = 1;
      end
    end else if (m_pause) begin
      m_pause = 0;
      if (has(m_sel)) m_latch();
      else m_release();
    end else begin
      int w;
      w = pick(hp);
      if (w >= 0) begin
        m_sel = w;
        m_latch();
      end
    end
  endtask

  task automatic check_model();
    chk("req",    int'(o_req),       int'(m_req));
    chk("grant",  int'(o_grant),     int'(m_grant));
    chk("done",   int'(o_pkt_done),  int'(m_grant && last));
    chk("sel",    int'(selected_vc), m_sel);
    chk("dest",   int'(o_dest),      int'(m_dest));
    chk("out_vc", int'(o_out_vc),    m_ovc);
`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
    chk("timeout", int'(o_timeout), int'(m_req && has(m_sel) && !cts && m_wait == TMO - 1));
`endif
  endtask

  // One cycle: drive at the falling edge, compare shortly after, then step the model.
  task automatic cyc(input logic [NV-1:0] h, input bit c, input bit l);
    @(negedge clk);
    hp = h; cts = c; last = l;
    for (int v = 0; v < NV; v++) begin
      dest_i[v] = OUTN'(1) << $urandom_range(OUTN - 1);
      ovc_i[v]  = SW'($urandom_range(NV - 1));
    end
    #1;
    check_model();
    m_step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hp = '0; cts = 1'b0; last = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [NV-1:0] hp;
    bit            cts;
    bit            last;
    bit            req;
    bit            grant;
    bit            done;
    int            sel;
  } vec_t;

  vec_t tbl [15];
  int   got [$];
  logic [NV-1:0] hp_r;
  bit   rc, rl;

  initial begin
    reset = 1'b1;
    hp = '0; cts = 1'b0; last = 1'b0; dest_i = '0; ovc_i = '0;

    // Single VC 2: request, cts two cycles after o_req, five-beat packet, second packet, release.
    tbl[0]  = '{6'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{6'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[2]  = '{6'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[3]  = '{6'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[4]  = '{6'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[5]  = '{6'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[6]  = '{6'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[7]  = '{6'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[8]  = '{6'h04, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    tbl[9]  = '{6'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[10] = '{6'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[11] = '{6'h04, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    tbl[12] = '{6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[13] = '{6'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[14] = '{6'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].hp, tbl[i].cts, tbl[i].last);
      chk($sformatf("tbl%0d_req", i),   int'(o_req),       int'(tbl[i].req));
      chk($sformatf("tbl%0d_grant", i), int'(o_grant),     int'(tbl[i].grant));
      chk($sformatf("tbl%0d_done", i),  int'(o_pkt_done),  int'(tbl[i].done));
      chk($sformatf("tbl%0d_sel", i),   int'(selected_vc), tbl[i].sel);
    end

    // Class priority: VC3 (class 1) beats VC0, then VC0 once VC3 drains.
    do_reset();
    cyc(6'h09, 1'b0, 1'b0);
    cyc(6'h09, 1'b0, 1'b0);
    chk("prio_first_sel", int'(selected_vc), 3);
    chk("prio_first_req", int'(o_req), 1);
    cyc(6'h09, 1'b1, 1'b0);
    cyc(6'h09, 1'b0, 1'b1);
    chk("prio_done", int'(o_pkt_done), 1);
    cyc(6'h01, 1'b0, 1'b0);
    cyc(6'h01, 1'b0, 1'b0);
    cyc(6'h01, 1'b0, 1'b0);
    chk("prio_second_sel", int'(selected_vc), 0);
    chk("prio_second_req", int'(o_req), 1);

    // Withdraw coinciding with cts: back to IDLE, pointer moves past VC1.
    do_reset();
    cyc(6'h02, 1'b0, 1'b0);
    cyc(6'h02, 1'b0, 1'b0);
    chk("wd_req", int'(o_req), 1);
    chk("wd_sel", int'(selected_vc), 1);
    cyc(6'h00, 1'b1, 1'b0);
    cyc(6'h00, 1'b0, 1'b0);
    chk("wd_idle_req", int'(o_req), 0);
    chk("wd_idle_grant", int'(o_grant), 0);
    cyc(6'h07, 1'b0, 1'b0);
    cyc(6'h07, 1'b1, 1'b0);
    chk("wd_next_sel", int'(selected_vc), 2);
    cyc(6'h07, 1'b0, 1'b0);
    chk("mid_xfer_grant", int'(o_grant), 1);

    // Reset while granted: outputs drop before any clock edge, pointers restart at 0.
    last = 1'b1;
    #1;
    chk("mid_xfer_done", int'(o_pkt_done), 1);
    reset = 1'b1;
    #1;
    chk("rst_req",    int'(o_req), 0);
    chk("rst_grant",  int'(o_grant), 0);
    chk("rst_done",   int'(o_pkt_done), 0);
    chk("rst_sel",    int'(selected_vc), 0);
    chk("rst_dest",   int'(o_dest), 0);
    chk("rst_out_vc", int'(o_out_vc), 0);
    m_reset();
    hp = '0; cts = 1'b0; last = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(6'h07, 1'b0, 1'b0);
    cyc(6'h07, 1'b0, 1'b0);
    chk("post_rst_sel", int'(selected_vc), 0);
    chk("post_rst_req", int'(o_req), 1);

    // Round robin over VCs 0..2 with cts and last always high.
    do_reset();
    for (int i = 0; i < 40 && got.size() < 7; i++) begin
      cyc(6'h07, 1'b1, 1'b1);
      if (o_grant && o_pkt_done) got.push_back(int'(selected_vc));
    end
    chk("rr_count", got.size(), 7);
    for (int i = 0; i < got.size() && i < 7; i++) begin
      chk($sformatf("rr_order%0d", i), got[i], (i / MAXP) % VCN);
    end

`ifdef VC_INPUT_ARB_REQ_TIMEOUT_EN
    // Blocked output: cts never comes, requests must time out and rotate.
    do_reset();
    for (int i = 0; i < 30; i++) cyc(6'h03, 1'b0, 1'b0);
`endif

    // Randomized traffic against the model.
    do_reset();
    hp_r = NV'($urandom_range(63));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) hp_r ^= NV'(1 << $urandom_range(NV - 1));
      rc = 1'($urandom_range(1));
      rl = ($urandom_range(2) == 0);
      cyc(hp_r, rc, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
